// File: rtl/viterbi_conv_encoder_k9_if.sv
// ============================================================================
// Module   : viterbi_conv_encoder_k9_if
// Brief    : Bit-in / symbol-out bundle for the K=9 rate-1/2 convolutional encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface viterbi_conv_encoder_k9_if #(
  parameter int K = 9
);
  logic         x;
  logic [1:0]   y;
  logic [K-1:0] wa;
  logic [K-1:0] wb;
  logic [K-1:0] shreg;

  modport master (
    output x,
    input  y,
    input  wa,
    input  wb,
    input  shreg
  );

  modport slave (
    input  x,
    output y,
    output wa,
    output wb,
    output shreg
  );
endinterface

`default_nettype wire

// File: rtl/viterbi_conv_encoder_k9.sv
// ============================================================================
// Module   : viterbi_conv_encoder_k9
// Brief    : Rate-1/2, K=9 feed-forward convolutional encoder, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_conv_encoder_k9 #(
  parameter int           K  = 9,
  parameter logic [K-1:0] WA = 9'o753,
  parameter logic [K-1:0] WB = 9'o561
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  viterbi_conv_encoder_k9_if.slave  enc
);

  logic [K-1:0] r_shreg;
  logic         w_branch_a;
  logic         w_branch_b;

  // Bit k of the register holds the input delayed by k clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else begin
      r_shreg <= {r_shreg[K-2:0], enc.x};
    end
  end

  assign w_branch_a = ^(r_shreg & WA);
  assign w_branch_b = ^(r_shreg & WB);

  assign enc.y     = {w_branch_a, w_branch_b};
  assign enc.wa    = WA;
  assign enc.wb    = WB;
  assign enc.shreg = r_shreg;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_conv_encoder_k9.sv
// ============================================================================
// Module   : tb_viterbi_conv_encoder_k9
// Brief    : Self-checking bench; expected symbols come from a convolution model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_conv_encoder_k9;

  localparam int         c_K  = 9;
  localparam logic [8:0] c_WA = 9'o753;
  localparam logic [8:0] c_WB = 9'o561;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  bit   hist[$];

  viterbi_conv_encoder_k9_if #(.K(c_K)) enc_if ();

  viterbi_conv_encoder_k9 #(.K(c_K), .WA(c_WA), .WB(c_WB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enc   (enc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit k of the model register is the input seen k clocks ago (zero before reset release).
  function automatic logic [8:0] model_shreg();
    logic [8:0] s;
    int idx;
    s = '0;
    for (int k = 0; k < 9; k++) begin
      idx = hist.size() - 1 - k;
      if (idx >= 0) s[k] = hist[idx];
    end
    return s;
  endfunction

  // Each branch is the mod-2 sum of past inputs weighted by the generator taps.
  function automatic logic [1:0] model_y();
    int sa, sb, idx;
    sa = 0;
    sb = 0;
    for (int k = 0; k < 9; k++) begin
      idx = hist.size() - 1 - k;
      if (idx >= 0 && hist[idx]) begin
        sa += int'(c_WA[k]);
        sb += int'(c_WB[k]);
      end
    end
    return {1'(sa % 2), 1'(sb % 2)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
  endtask

  task automatic drive_bit(input bit b, output logic [1:0] y_obs);
    enc_if.x = b;
    @(posedge clk);
    hist.push_back(b);
    @(negedge clk);
    y_obs = enc_if.y;
    check_eq("shreg_model", 32'(enc_if.shreg), 32'(model_shreg()));
    check_eq("y_model", 32'(enc_if.y), 32'(model_y()));
  endtask

  logic [1:0] y_obs;
  bit   ref_x [13] = '{0,1,0,1,0,0,0,1,0,1,1,0,1};
  logic [1:0] ref_y [13] = '{2'b00,2'b11,2'b10,2'b11,2'b00,2'b01,2'b01,2'b01,2'b11,2'b11,2'b01,2'b00,2'b10};
  logic [1:0] imp_y [11] = '{2'b00,2'b11,2'b10,2'b00,2'b10,2'b01,2'b11,2'b11,2'b10,2'b11,2'b00};
  bit   u1 [40];
  bit   u2 [40];
  logic [1:0] y1 [40];
  logic [1:0] y2 [40];
  logic [1:0] y3 [40];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    enc_if.x = 1'b0;

    // Reset held with X toggling
    for (int i = 0; i < 3; i++) begin
      enc_if.x = ~enc_if.x;
      @(negedge clk);
      check_eq("rst_shreg", 32'(enc_if.shreg), 32'h0);
      check_eq("rst_y", 32'(enc_if.y), 32'h0);
      check_eq("rst_wa", 32'(enc_if.wa), 32'(9'o753));
      check_eq("rst_wb", 32'(enc_if.wb), 32'(9'o561));
    end
    hist.delete();
    rst_n = 1'b1;

    // Impulse response: 0, 1, then zeros until the 1 leaves the register
    for (int i = 0; i < 11; i++) begin
      drive_bit(i == 1, y_obs);
      check_eq("impulse_y", 32'(y_obs), 32'(imp_y[i]));
      if (i >= 1 && i <= 9) check_eq("impulse_shreg", 32'(enc_if.shreg), 32'(1 << (i - 1)));
    end

    // Reference sequence from reset
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive_bit(ref_x[i], y_obs);
      check_eq("ref_y", 32'(y_obs), 32'(ref_y[i]));
    end

    // Asynchronous reset between edges while the register is nonzero
    check_eq("pre_async_nonzero", 32'(enc_if.shreg != 0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_shreg", 32'(enc_if.shreg), 32'h0);
    check_eq("async_y", 32'(enc_if.y), 32'h0);
    @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive_bit(ref_x[i], y_obs);
      check_eq("ref2_y", 32'(y_obs), 32'(ref_y[i]));
    end

    // All-ones saturation then zero flush
    for (int i = 0; i < 12; i++) drive_bit(1'b1, y_obs);
    check_eq("ones_y", 32'(y_obs), 32'h3);
    check_eq("ones_shreg", 32'(enc_if.shreg), 32'h1ff);
    for (int i = 0; i < 9; i++) drive_bit(1'b0, y_obs);
    check_eq("flush_y", 32'(y_obs), 32'h0);
    check_eq("flush_shreg", 32'(enc_if.shreg), 32'h0);

    // Random stream against the model
    do_reset();
    for (int i = 0; i < 200; i++) drive_bit(1'($urandom_range(0, 1)), y_obs);

    // Linearity: encode(u1^u2) == encode(u1)^encode(u2)
    for (int i = 0; i < 40; i++) begin
      u1[i] = 1'($urandom_range(0, 1));
      u2[i] = 1'($urandom_range(0, 1));
    end
    do_reset();
    for (int i = 0; i < 40; i++) begin drive_bit(u1[i], y_obs); y1[i] = y_obs; end
    do_reset();
    for (int i = 0; i < 40; i++) begin drive_bit(u2[i], y_obs); y2[i] = y_obs; end
    do_reset();
    for (int i = 0; i < 40; i++) begin drive_bit(u1[i] ^ u2[i], y_obs); y3[i] = y_obs; end
    for (int i = 0; i < 40; i++) check_eq("linearity", 32'(y3[i]), 32'(y1[i] ^ y2[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/viterbi_conv_encoder_k9.md
Name:
viterbi_conv_encoder_k9

Overview:
- Rate-1/2, constraint-length-9, feed-forward convolutional encoder; the transmit-side front end of the Viterbi codec.
- One input bit per clock produces one 2-bit code symbol.
- Generator polynomials are parameters and are also driven out as constants, so the downstream Viterbi decoder and debug logic use the same taps.
- The internal shift register is exported for observation.

Parameters:
- K, 9, constraint length; width of shift register and generator words (fixed at 9 for this block).
- WA, 9'o753, generator polynomial A; bit k taps the input delayed by k clocks.
- WB, 9'o561, generator polynomial B; same bit convention.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset; clears the shift register.
- X      input  1  information bit, sampled on each rising Clock edge.
- Y      output 2  code symbol; Y[1] = branch A, Y[0] = branch B.
- wA     output 9  constant copy of WA.
- wB     output 9  constant copy of WB.
- ShReg  output 9  current shift-register contents; ShReg[0] = newest bit, ShReg[8] = oldest.

Behaviour:
- One clock domain, Clock. Reset is asynchronous and active-low.
- Reset asserted (Reset=0), immediately and regardless of Clock: ShReg = 9'b0, so Y = 2'b00.
- Reset mid-stream: encoder state is discarded and the next sampled X starts from the all-zero state.
- Each rising Clock edge with Reset=1: ShReg <= {ShReg[7:0], X}. Bit 8 is discarded. There is no enable, so a shift happens every cycle.
- Y is combinational from ShReg:
  - Y[1] = XOR-reduce(ShReg & WA)
  - Y[0] = XOR-reduce(ShReg & WB)
- Latency: the symbol for bit X sampled at edge n is valid after edge n (after settling) and holds until edge n+1.
- Tap positions:
  - WA taps delays 0,1,3,5,6,7,8.
  - WB taps delays 0,4,5,6,8.
- wA and wB are tied to WA and WB. They are constant, including during reset.
- No handshake, no idle state; every cycle consumes exactly one bit.
- A continuous zero input flushes the encoder. After 9 zero bits, ShReg = 0 and Y = 00.
- Clock and reset sharing an edge: reset wins.

Test Plan:
- Reset: hold Reset=0 for 3 clocks with X toggling -> ShReg=000000000, Y=00, wA=9'o753, wB=9'o561 throughout.
- Impulse: release reset, feed 0, then 1 followed by zeros -> Y per cycle = 00, then 11,10,00,10,01,11,11,10,11, then 00 once the 1 leaves bit 8. ShReg shows a single 1 moving from bit 0 to bit 8.
- Reference sequence after reset release: X = 0,1,0,1,0,0,0,1,0,1,1,0,1, each checked one period later (mid-cycle after the capturing edge) -> Y = 00,11,10,11,00,01,01,01,11,11,01,00,10.
- Async reset mid-stream: drive Reset=0 between edges while ShReg is nonzero -> ShReg and Y go to 0 before the next edge. After release, the reference sequence reproduces the same outputs.
- All-ones input for 9+ cycles -> Y settles to 11 (WA weight 7 is odd, WB weight 5 is odd). Then 9 zeros -> Y returns to 00, ShReg = 0.
- Linearity check: the encoded output of random stream u1 XOR u2 equals encode(u1) XOR encode(u2), cycle by cycle, both started from reset.
